fp_alu: RTL and testbench
=========================

Name: fp_alu

Overview:
- Pipelined floating-point arithmetic unit for the FPU datapath.
- Each cycle it accepts two operands in the project's 29-bit "uni" format: 1-bit sign, 6-bit exponent, 22-bit explicit left-aligned mantissa.
- It returns their sum or product, selected by add_muln, in the same format after a fixed latency.
- It has no handshake: it is a free-running, fully pipelined block that accepts a new operation every cycle.

Parameters:
- EXP_W, 6: exponent width.
- MAN_W, 22: mantissa width; explicit leading bit, no hidden bit.
- BIAS, 31: exponent bias.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  synchronous active-low reset.
- din_uni_a_sgn  input  1  operand A sign (1 = negative).
- din_uni_a_exp  input  6  operand A biased exponent.
- din_uni_a_man_dn  input  22  operand A mantissa, left-aligned, may be denormal.
- din_uni_b_sgn  input  1  operand B sign.
- din_uni_b_exp  input  6  operand B biased exponent.
- din_uni_b_man_dn  input  22  operand B mantissa.
- add_muln  input  1  1 = add (A+B), 0 = multiply (A×B).
- dout_uni_y_sgn  output  1  result sign.
- dout_uni_y_exp  output  6  result exponent.
- dout_uni_y_man_dn  output  22  result mantissa.

Behaviour:
- Number format: value = (-1)^sgn × (man / 2^21) × 2^(exp − 31).
  - Normalized: man[21] = 1.
  - Zero: man = 0, any exponent.
  - Denormal inputs (man[21] = 0) are legal and handled exactly like any other value.
- Latency and throughput:
  - Latency is 3 clocks: operands and add_muln are sampled at edge N; the result is valid after edge N+2.
  - Throughput is one operation per clock.
  - add_muln travels with its operands through the pipeline.
- Pipeline stages:
  - S1: unpack, compare exponents, align the smaller addend (right shift with 3 guard bits plus sticky), or form the 44-bit mantissa product.
  - S2: add/subtract magnitudes, leading-zero count.
  - S3: normalize, apply exponent limits, pack.
  - All outputs come directly from flops.
- Add:
  - Effective subtraction when the signs differ; subtract the smaller magnitude from the larger.
  - The result sign is the sign of the larger magnitude.
  - Carry-out: shift right 1, exp+1.
- Multiply:
  - Sign = sa XOR sb.
  - Exponent = ea + eb − 31, computed in 8-bit signed arithmetic.
  - If product bit 43 = 1: exp+1 and take bits [43:22]; otherwise normalize left by the leading-zero count.
- Rounding: truncation (round toward zero) for both operations.
- Normalization: the result is left-shifted until man[21] = 1, unless exp would go below 0. In that case exp = 0 and the mantissa keeps the remaining leading zeros (gradual underflow). A multiply exponent below 0 right-shifts the mantissa by the deficit, truncating.
- Overflow: exponent > 63 saturates to exp = 63, man = 0x3FFFFF, with the correct sign.
- Zero result:
  - Output sgn = 0, exp = 0, man = 0.
  - Exception for add: −0 + −0 gives sgn = 1.
  - A multiply with either operand zero yields zero with sign sa XOR sb.
- Reset:
  - rst_n low at an edge clears all pipeline registers and outputs to 0.
  - An operation in flight when reset asserts is discarded.
  - Results resume 3 edges after the first sampled operation following reset deassertion.

Decomposition:
- Shared package fpu_pkg holds:
  - EXP_W, MAN_W, BIAS;
  - a packed struct for the uni format (sgn, exp, man_dn);
  - the constants EXP_MAX = 63 and MAN_ONE = 22'h200000.
- One sub-module is natural: fp_lzc, a parametric leading-zero counter (44-bit input), used by both the add and multiply normalize paths.

Test Plan:
- Add 1.0 + 1.0 (exp 31, man 0x200000 each; signs 0) → after 3 edges: sgn 0, exp 32, man 0x200000.
- Multiply 1.5 × 2.0 (exp 31, man 0x300000; exp 32, man 0x200000) → sgn 0, exp 32, man 0x300000.
- Cancellation: add 1.0 + (−1.0) → sgn 0, exp 0, man 0. Then 1.0 + (−0.75) (exp 30, man 0x300000) → sgn 0, exp 29, man 0x200000.
- Overflow: multiply (exp 63, man 0x200000) × (exp 63, man 0x200000) → exp 63, man 0x3FFFFF, sgn 0. Underflow: multiply exp 1 × exp 1 gives exp 0 with a right-shifted mantissa.
- Back-to-back pipelining: issue add, mul, add on consecutive cycles with distinct operands → three correct results on consecutive cycles in issue order, each 3 edges after issue.
- Reset: assert rst_n = 0 for 1 edge while ops are in flight → outputs all 0 at that edge; in-flight results are never produced.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared definitions for the uni floating-point format used across the FPU datapath.
// value = (-1)^sgn * (man_dn / 2^21) * 2^(exp - 31); mantissa carries an explicit leading bit.
package fpu_pkg;
  localparam int EXP_W = 6;
  localparam int MAN_W = 22;
  localparam int BIAS  = 31;

  localparam logic [EXP_W-1:0] EXP_MAX = 6'd63;
  localparam logic [MAN_W-1:0] MAN_ONE = 22'h200000;

  typedef struct packed {
    logic             sgn;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] man_dn;
  } uni_t;
endpackage

// File: rtl/fp_lzc.sv
// Combinational leading-zero counter; an all-zero input reports W.
// No state, no latency, no backpressure.
module fp_lzc #(
  parameter int W = 44,
  localparam int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  din,
  output logic [CW-1:0] cnt
);
  always_comb begin
    cnt = CW'(W);
    // Scanning upward lets the most significant set bit win.
    for (int i = 0; i < W; i++) begin
      if (din[i]) cnt = CW'(W - 1 - i);
    end
  end
endmodule

// File: rtl/fp_alu.sv
// Pipelined uni-format add/multiply with truncation; result registered 3 edges after sampling.
// No backpressure: a new operation is accepted on every clock.
module fp_alu
  import fpu_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din_uni_a_sgn,
  input  logic [EXP_W-1:0] din_uni_a_exp,
  input  logic [MAN_W-1:0] din_uni_a_man_dn,
  input  logic             din_uni_b_sgn,
  input  logic [EXP_W-1:0] din_uni_b_exp,
  input  logic [MAN_W-1:0] din_uni_b_man_dn,
  input  logic             add_muln,
  output logic             dout_uni_y_sgn,
  output logic [EXP_W-1:0] dout_uni_y_exp,
  output logic [MAN_W-1:0] dout_uni_y_man_dn
);
  localparam int ALN_W = MAN_W + 3;
  localparam int PRD_W = 2 * MAN_W;
  localparam int LZ_W  = $clog2(PRD_W + 1);
  localparam int E_W   = EXP_W + 2;
  localparam logic signed [E_W-1:0] E_ADJ   = E_W'(BIAS - 1);
  localparam logic signed [E_W-1:0] EXP_LIM = E_W'(EXP_MAX);

  uni_t a, b;
  assign a = {din_uni_a_sgn, din_uni_a_exp, din_uni_a_man_dn};
  assign b = {din_uni_b_sgn, din_uni_b_exp, din_uni_b_man_dn};

  // S1: order addends by exponent, align the smaller one, form the product.
  logic                  swap, big_sgn, a_zero, b_zero;
  logic [EXP_W-1:0]      big_exp, dexp;
  logic [ALN_W-1:0]      big_ext, small_full, small_ext, lost_mask;
  logic signed [E_W-1:0] e0;

  assign a_zero = (a.man_dn == '0);
  assign b_zero = (b.man_dn == '0);

  always_comb begin
    swap       = (b.exp > a.exp) || ((b.exp == a.exp) && (b.man_dn > a.man_dn));
    big_exp    = swap ? b.exp : a.exp;
    big_sgn    = swap ? b.sgn : a.sgn;
    big_ext    = {(swap ? b.man_dn : a.man_dn), 3'b000};
    small_full = {(swap ? a.man_dn : b.man_dn), 3'b000};
    dexp       = swap ? (b.exp - a.exp) : (a.exp - b.exp);
    lost_mask  = ~({ALN_W{1'b1}} << dexp);
    small_ext  = (small_full >> dexp) | {{(ALN_W-1){1'b0}}, |(small_full & lost_mask)};
    // Both paths share one exponent convention: mantissa read from the top 22 bits of a 44-bit frame.
    e0 = add_muln ? ($signed(E_W'(big_exp)) + 8'sd1)
                  : ($signed(E_W'(a.exp)) + $signed(E_W'(b.exp)) - E_ADJ);
  end

  logic                  r1_add, r1_sub, r1_sgn, r1_zsgn;
  logic signed [E_W-1:0] r1_e0;
  logic [ALN_W-1:0]      r1_big, r1_small;
  logic [PRD_W-1:0]      r1_prod;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r1_add   <= 1'b0;
      r1_sub   <= 1'b0;
      r1_sgn   <= 1'b0;
      r1_zsgn  <= 1'b0;
      r1_e0    <= '0;
      r1_big   <= '0;
      r1_small <= '0;
      r1_prod  <= '0;
    end else begin
      r1_add   <= add_muln;
      r1_sub   <= add_muln & (a.sgn ^ b.sgn);
      r1_sgn   <= add_muln ? big_sgn : (a.sgn ^ b.sgn);
      r1_zsgn  <= add_muln ? (a.sgn & b.sgn & a_zero & b_zero)
                           : ((a.sgn ^ b.sgn) & (a_zero | b_zero));
      r1_e0    <= e0;
      r1_big   <= big_ext;
      r1_small <= small_ext;
      r1_prod  <= PRD_W'(a.man_dn) * PRD_W'(b.man_dn);
    end
  end

  // S2: magnitude add/subtract, then leading-zero count on the common frame.
  logic [ALN_W:0]   sum;
  logic             neg;
  logic [PRD_W-1:0] frame;
  logic [LZ_W-1:0]  lz;

  always_comb begin
    // Denormal operands can make the aligned subtrahend the larger one.
    neg = r1_sub && (r1_small > r1_big);
    if (!r1_sub)  sum = {1'b0, r1_big} + {1'b0, r1_small};
    else if (neg) sum = {1'b0, r1_small - r1_big};
    else          sum = {1'b0, r1_big - r1_small};
    frame = r1_add ? {sum, {(PRD_W-ALN_W-1){1'b0}}} : r1_prod;
  end

  fp_lzc #(.W(PRD_W)) u_lzc (
    .din (frame),
    .cnt (lz)
  );

  logic                  r2_sgn, r2_zsgn;
  logic signed [E_W-1:0] r2_e0;
  logic [PRD_W-1:0]      r2_m;
  logic [LZ_W-1:0]       r2_lz;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r2_sgn  <= 1'b0;
      r2_zsgn <= 1'b0;
      r2_e0   <= '0;
      r2_m    <= '0;
      r2_lz   <= '0;
    end else begin
      r2_sgn  <= r1_sgn ^ neg;
      r2_zsgn <= r1_zsgn;
      r2_e0   <= r1_e0;
      r2_m    <= frame;
      r2_lz   <= lz;
    end
  end

  // S3: normalize left without dropping the exponent below 0, or right-shift an underflowed product.
  logic [E_W-1:0]        shamt;
  logic [MAN_W-1:0]      man_n;
  logic signed [E_W-1:0] exp_n;

  always_comb begin
    shamt = '0;
    man_n = '0;
    exp_n = '0;
    if (r2_e0 < 0) begin
      shamt = E_W'(-r2_e0);
      man_n = r2_m[PRD_W-1 -: MAN_W] >> shamt;
    end else begin
      shamt = (E_W'(r2_lz) < $unsigned(r2_e0)) ? E_W'(r2_lz) : $unsigned(r2_e0);
      man_n = MAN_W'((r2_m << shamt) >> (PRD_W - MAN_W));
      exp_n = r2_e0 - $signed(shamt);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dout_uni_y_sgn    <= 1'b0;
      dout_uni_y_exp    <= '0;
      dout_uni_y_man_dn <= '0;
    end else if (man_n == '0) begin
      dout_uni_y_sgn    <= r2_zsgn;
      dout_uni_y_exp    <= '0;
      dout_uni_y_man_dn <= '0;
    end else if (exp_n > EXP_LIM) begin
      dout_uni_y_sgn    <= r2_sgn;
      dout_uni_y_exp    <= EXP_MAX;
      dout_uni_y_man_dn <= '1;
    end else begin
      dout_uni_y_sgn    <= r2_sgn;
      dout_uni_y_exp    <= exp_n[EXP_W-1:0];
      dout_uni_y_man_dn <= man_n;
    end
  end
endmodule

// File: tb/tb_fp_alu.sv
// Self-checking bench for fp_alu: directed corner cases plus a randomized stream
// compared against an integer-arithmetic reference model.
module tb_fp_alu;
  typedef struct packed {
    logic        add;
    logic        sa;
    logic [5:0]  ea;
    logic [21:0] ma;
    logic        sb;
    logic [5:0]  eb;
    logic [21:0] mb;
    logic [28:0] want;
  } vec_t;

  localparam longint P24 = 64'sd1 << 24;
  localparam longint P25 = 64'sd1 << 25;
  localparam longint P42 = 64'sd1 << 42;
  localparam longint P43 = 64'sd1 << 43;

  logic        clk;
  logic        rst_n;
  logic        a_sgn, b_sgn, add_muln;
  logic [5:0]  a_exp, b_exp;
  logic [21:0] a_man, b_man;
  logic        y_sgn;
  logic [5:0]  y_exp;
  logic [21:0] y_man;
  logic [28:0] y;

  int checks = 0;
  int errors = 0;

  assign y = {y_sgn, y_exp, y_man};

  fp_alu dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .din_uni_a_sgn     (a_sgn),
    .din_uni_a_exp     (a_exp),
    .din_uni_a_man_dn  (a_man),
    .din_uni_b_sgn     (b_sgn),
    .din_uni_b_exp     (b_exp),
    .din_uni_b_man_dn  (b_man),
    .add_muln          (add_muln),
    .dout_uni_y_sgn    (y_sgn),
    .dout_uni_y_exp    (y_exp),
    .dout_uni_y_man_dn (y_man)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  // Reference model: exact value arithmetic on scaled integers, truncated to 22 bits.
  function automatic logic [28:0] model(input vec_t v);
    longint big, sml, al, x, m, man;
    int     e, d;
    logic   sbig, ssml, s, zs;
    if (v.add) begin
      zs = v.sa & v.sb & (v.ma == 0) & (v.mb == 0);
      if (v.ea >= v.eb) begin
        big = longint'(v.ma) * 8; sml = longint'(v.mb) * 8;
        sbig = v.sa; ssml = v.sb; e = int'(v.ea); d = int'(v.ea) - int'(v.eb);
      end else begin
        big = longint'(v.mb) * 8; sml = longint'(v.ma) * 8;
        sbig = v.sb; ssml = v.sa; e = int'(v.eb); d = int'(v.eb) - int'(v.ea);
      end
      al = sml >> d;
      if ((al << d) != sml) al = al | 1;
      x = (sbig ? -big : big) + (ssml ? -al : al);
      s = (x < 0);
      m = s ? -x : x;
      if (m >= P25) begin m = m >> 1; e = e + 1; end
      while (m < P24 && e > 0) begin m = m << 1; e = e - 1; end
      man = m >> 3;
    end else begin
      zs = (v.sa ^ v.sb) & ((v.ma == 0) | (v.mb == 0));
      s  = v.sa ^ v.sb;
      m  = longint'(v.ma) * longint'(v.mb);
      e  = int'(v.ea) + int'(v.eb) - 31;
      if (m >= P43) begin m = m >> 1; e = e + 1; end
      while (m < P42 && e > 0) begin m = m << 1; e = e - 1; end
      if (e < 0) begin
        man = (m >> 21) >> (-e);
        e = 0;
      end else begin
        man = m >> 21;
      end
    end
    if (man == 0) return {zs, 6'd0, 22'd0};
    if (e > 63) return {s, 6'd63, 22'h3FFFFF};
    return {s, 6'(e), man[21:0]};
  endfunction

  function automatic vec_t mk(input logic add, input logic sa, input logic [5:0] ea,
                              input logic [21:0] ma, input logic sb, input logic [5:0] eb,
                              input logic [21:0] mb, input logic [28:0] want);
    vec_t v;
    v.add = add; v.sa = sa; v.ea = ea; v.ma = ma;
    v.sb = sb; v.eb = eb; v.mb = mb; v.want = want;
    return v;
  endfunction

  function automatic logic [21:0] rand_man();
    logic [21:0] r;
    int          k;
    r = 22'($urandom);
    k = $urandom_range(0, 9);
    if (k < 7)      r[21] = 1'b1;
    else if (k < 9) r = r >> $urandom_range(1, 21);
    else            r = '0;
    return r;
  endfunction

  function automatic vec_t rand_vec();
    vec_t v;
    v.add = 1'($urandom_range(0, 1));
    v.sa  = 1'($urandom_range(0, 1));
    v.sb  = 1'($urandom_range(0, 1));
    v.ea  = 6'($urandom_range(0, 63));
    v.eb  = ($urandom_range(0, 1) == 1) ? (v.ea ^ 6'($urandom_range(0, 3)))
                                        : 6'($urandom_range(0, 63));
    v.ma  = rand_man();
    v.mb  = rand_man();
    v.want = model(v);
    return v;
  endfunction

  task automatic drive(input vec_t v);
    add_muln = v.add;
    a_sgn = v.sa; a_exp = v.ea; a_man = v.ma;
    b_sgn = v.sb; b_exp = v.eb; b_man = v.mb;
  endtask

  task automatic run_one(input vec_t v, output logic [28:0] got);
    drive(v);
    repeat (3) @(posedge clk);
    @(negedge clk);
    got = y;
  endtask

  task automatic test_reset;
    vec_t v;
    v = mk(1'b1, 1'b0, 6'd31, 22'h200000, 1'b0, 6'd31, 22'h200000, 29'd0);
    rst_n = 1'b0;
    drive(v);
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (y !== 29'd0) begin
      errors++;
      $display("FAIL reset_state got %h want %h", y, 29'd0);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_add;
    vec_t        v[6];
    logic [28:0] got;
    v[0] = mk(1'b1, 1'b0, 6'd31, 22'h200000, 1'b0, 6'd31, 22'h200000, {1'b0, 6'd32, 22'h200000});
    v[1] = mk(1'b1, 1'b0, 6'd31, 22'h200000, 1'b1, 6'd31, 22'h200000, {1'b0, 6'd0, 22'h000000});
    v[2] = mk(1'b1, 1'b0, 6'd31, 22'h200000, 1'b1, 6'd30, 22'h300000, {1'b0, 6'd29, 22'h200000});
    v[3] = mk(1'b1, 1'b1, 6'd5, 22'h000000, 1'b1, 6'd9, 22'h000000, {1'b1, 6'd0, 22'h000000});
    v[4] = mk(1'b1, 1'b0, 6'd63, 22'h200000, 1'b0, 6'd63, 22'h200000, {1'b0, 6'd63, 22'h3FFFFF});
    v[5] = mk(1'b1, 1'b1, 6'd31, 22'h300000, 1'b1, 6'd30, 22'h200000, {1'b1, 6'd32, 22'h200000});
    for (int i = 0; i < 6; i++) begin
      run_one(v[i], got);
      checks++;
      if (got !== v[i].want) begin
        errors++;
        $display("FAIL add[%0d] got %h want %h", i, got, v[i].want);
      end
    end
  endtask

  task automatic test_mul;
    vec_t        v[7];
    logic [28:0] got;
    v[0] = mk(1'b0, 1'b0, 6'd31, 22'h300000, 1'b0, 6'd32, 22'h200000, {1'b0, 6'd32, 22'h300000});
    v[1] = mk(1'b0, 1'b0, 6'd63, 22'h200000, 1'b0, 6'd63, 22'h200000, {1'b0, 6'd63, 22'h3FFFFF});
    v[2] = mk(1'b0, 1'b1, 6'd63, 22'h200000, 1'b0, 6'd63, 22'h200000, {1'b1, 6'd63, 22'h3FFFFF});
    v[3] = mk(1'b0, 1'b0, 6'd20, 22'h200000, 1'b0, 6'd8, 22'h200000, {1'b0, 6'd0, 22'h040000});
    v[4] = mk(1'b0, 1'b0, 6'd1, 22'h200000, 1'b0, 6'd1, 22'h200000, {1'b0, 6'd0, 22'h000000});
    v[5] = mk(1'b0, 1'b0, 6'd40, 22'h000000, 1'b1, 6'd31, 22'h200000, {1'b1, 6'd0, 22'h000000});
    v[6] = mk(1'b0, 1'b0, 6'd31, 22'h100000, 1'b0, 6'd31, 22'h200000, {1'b0, 6'd30, 22'h200000});
    for (int i = 0; i < 7; i++) begin
      run_one(v[i], got);
      checks++;
      if (got !== v[i].want) begin
        errors++;
        $display("FAIL mul[%0d] got %h want %h", i, got, v[i].want);
      end
    end
  endtask

  task automatic test_back_to_back;
    vec_t v[3];
    v[0] = mk(1'b1, 1'b0, 6'd31, 22'h200000, 1'b0, 6'd31, 22'h200000, {1'b0, 6'd32, 22'h200000});
    v[1] = mk(1'b0, 1'b0, 6'd31, 22'h300000, 1'b0, 6'd32, 22'h200000, {1'b0, 6'd32, 22'h300000});
    v[2] = mk(1'b1, 1'b0, 6'd31, 22'h200000, 1'b1, 6'd30, 22'h300000, {1'b0, 6'd29, 22'h200000});
    for (int i = 0; i < 6; i++) begin
      if (i >= 3) begin
        checks++;
        if (y !== v[i-3].want) begin
          errors++;
          $display("FAIL b2b[%0d] got %h want %h", i - 3, y, v[i-3].want);
        end
      end
      if (i < 3) drive(v[i]);
      if (i < 5) @(negedge clk);
    end
  endtask

  task automatic test_reset_inflight;
    vec_t        v[3];
    vec_t        nxt;
    logic [28:0] want_after;
    v[0] = mk(1'b1, 1'b0, 6'd31, 22'h200000, 1'b0, 6'd31, 22'h200000, 29'd0);
    v[1] = mk(1'b0, 1'b1, 6'd33, 22'h280000, 1'b0, 6'd29, 22'h300000, 29'd0);
    v[2] = mk(1'b1, 1'b1, 6'd40, 22'h3F0000, 1'b1, 6'd38, 22'h220000, 29'd0);
    nxt  = mk(1'b0, 1'b0, 6'd31, 22'h300000, 1'b0, 6'd32, 22'h200000, 29'd0);
    want_after = {1'b0, 6'd32, 22'h300000};
    @(negedge clk);
    drive(v[0]);
    @(negedge clk);
    drive(v[1]);
    @(negedge clk);
    drive(v[2]);
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (y !== 29'd0) begin
      errors++;
      $display("FAIL reset_inflight_edge got %h want %h", y, 29'd0);
    end
    rst_n = 1'b1;
    drive(nxt);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      checks++;
      if (i < 3 && y !== 29'd0) begin
        errors++;
        $display("FAIL reset_drain[%0d] got %h want %h", i, y, 29'd0);
      end else if (i == 3 && y !== want_after) begin
        errors++;
        $display("FAIL reset_resume got %h want %h", y, want_after);
      end
    end
  endtask

  task automatic test_random(input int n);
    vec_t v;
    logic [28:0] exp_q[$];
    logic [28:0] want;
    for (int i = 0; i < n + 3; i++) begin
      if (i >= 3) begin
        want = exp_q.pop_front();
        checks++;
        if (y !== want) begin
          errors++;
          $display("FAIL random[%0d] got %h want %h", i - 3, y, want);
        end
      end
      if (i < n) begin
        v = rand_vec();
        drive(v);
        exp_q.push_back(v.want);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    drive(mk(1'b0, 1'b0, 6'd0, 22'd0, 1'b0, 6'd0, 22'd0, 29'd0));
    @(negedge clk);
    test_reset();
    test_add();
    test_mul();
    test_back_to_back();
    test_reset_inflight();
    test_random(400);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
